// File: rtl/universal_adder_pkg.sv
// Shared constants for the universal adder/subtractor datapath stage.
package universal_adder_pkg;

    // Mode encoding on the M input.
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Default operand/result width.
    localparam int DEFAULT_WIDTH = 4;

endpackage : universal_adder_pkg

// File: rtl/universal_adder_full_adder.sv
// One-bit full adder; the top level chains WIDTH of these into a ripple-carry adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum is the parity of the three inputs; carry is their majority.
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/universal_adder.sv
// Two's-complement adder/subtractor with registered sum, carry-out and signed-overflow
// flags. One cycle of latency, one operation per cycle, qualified by in_valid/out_valid.
module universal_adder
    import universal_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             M,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V,
    output logic             out_valid
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum_core;
    logic [WIDTH:0]   carry;
    logic             v_core;

    // Subtraction is A + ~B + 1: invert B and inject the +1 as the chain's carry-in.
    assign b_eff    = B ^ {WIDTH{M == MODE_SUB}};
    assign carry[0] = (M == MODE_SUB);

    // Ripple-carry chain, LSB first.
    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_adder u_fa (
            .a    (A[i]),
            .b    (b_eff[i]),
            .cin  (carry[i]),
            .sum  (sum_core[i]),
            .cout (carry[i+1])
        );
    end

    // Signed overflow: carry into the MSB disagrees with carry out of it. Valid for
    // both modes because subtraction is a genuine addition of the inverted operand.
    assign v_core = carry[WIDTH] ^ carry[WIDTH-1];

    // Output registers: load on an accepted operation, hold otherwise; out_valid pulses.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            S         <= '0;
            Cout      <= 1'b0;
            V         <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                S    <= sum_core;
                Cout <= carry[WIDTH];
                V    <= v_core;
            end
        end
    end

endmodule : universal_adder

// File: tb/tb_universal_adder.sv
// Directed and exhaustive self-checking bench for universal_adder at WIDTH=4.
module tb_universal_adder;
    import universal_adder_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         m_in;
    logic [W-1:0] s_out;
    logic         cout_out;
    logic         v_out;
    logic         out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    universal_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a_in),
        .B         (b_in),
        .M         (m_in),
        .S         (s_out),
        .Cout      (cout_out),
        .V         (v_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if observed differs from expected.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one accepted operation and check outputs just after the capturing edge.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m,
                         input logic [W-1:0] exp_s, input logic exp_c, input logic exp_v,
                         input string tag);
        @(negedge clk);
        a_in     = a;
        b_in     = b;
        m_in     = m;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, ".S"},         32'(s_out),     32'(exp_s));
        check({tag, ".Cout"},      32'(cout_out),  32'(exp_c));
        check({tag, ".V"},         32'(v_out),     32'(exp_v));
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    endtask

    initial begin
        logic [W:0]   ref_sum;
        logic [W-1:0] ref_b;
        logic [W-1:0] ref_s;
        logic         ref_v;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a_in     = '0;
        b_in     = '0;
        m_in     = MODE_ADD;
        #12;
        check("reset.S",         32'(s_out),     32'd0);
        check("reset.Cout",      32'(cout_out),  32'd0);
        check("reset.V",         32'(v_out),     32'd0);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, hand-computed.
        do_op(4'b0101, 4'b0011, MODE_ADD, 4'b1000, 1'b0, 1'b1, "add");
        do_op(4'b0111, 4'b1001, MODE_ADD, 4'b0000, 1'b1, 1'b0, "add_wrap");
        do_op(4'b1001, 4'b0100, MODE_SUB, 4'b0101, 1'b1, 1'b1, "sub");
        do_op(4'b0011, 4'b1000, MODE_SUB, 4'b1011, 1'b0, 1'b1, "sub_borrow");

        // in_valid low: outputs hold the last result, out_valid drops.
        @(negedge clk);
        a_in = 4'b1111;
        b_in = 4'b1111;
        m_in = MODE_ADD;
        @(posedge clk);
        #1;
        check("hold.S",         32'(s_out),     32'hB);
        check("hold.Cout",      32'(cout_out),  32'd0);
        check("hold.V",         32'(v_out),     32'd1);
        check("hold.out_valid", 32'(out_valid), 32'd0);

        // Back-to-back throughput: second op follows on the very next edge.
        do_op(4'b0001, 4'b0001, MODE_ADD, 4'b0010, 1'b0, 1'b0, "b2b_a");
        @(negedge clk);
        in_valid = 1'b1;
        a_in = 4'b0000;
        b_in = 4'b0001;
        m_in = MODE_SUB;
        @(posedge clk);
        #1;
        check("b2b_b.S",         32'(s_out),     32'hF);
        check("b2b_b.Cout",      32'(cout_out),  32'd0);
        check("b2b_b.out_valid", 32'(out_valid), 32'd1);

        // Reset asserted between edges clears outputs immediately and kills the in-flight op.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.S",         32'(s_out),     32'd0);
        check("async_rst.Cout",      32'(cout_out),  32'd0);
        check("async_rst.V",         32'(v_out),     32'd0);
        check("async_rst.out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold.S",         32'(s_out),     32'd0);
        check("rst_hold.out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First capture after reset release.
        do_op(4'b0010, 4'b0011, MODE_ADD, 4'b0101, 1'b0, 1'b0, "post_rst");

        // Exhaustive sweep against a 5-bit reference sum.
        for (int m = 0; m < 2; m++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    ref_b   = W'(b) ^ {W{m[0]}};
                    ref_sum = {1'b0, W'(a)} + {1'b0, ref_b} + {{W{1'b0}}, m[0]};
                    ref_s   = ref_sum[W-1:0];
                    ref_v   = (a[W-1] == ref_b[W-1]) && (ref_s[W-1] != a[W-1]);
                    do_op(W'(a), W'(b), m[0], ref_s, ref_sum[W], ref_v, "sweep");
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_universal_adder
